// File: rtl/fpu_types_pkg.sv
// Shared binary16 constants, rounding modes and accumulator state type.
// Classification helpers are used by the sticky NaN/inf status logic.
package fpu_types_pkg;

  localparam int HALF_FLOAT_W = 16;

  localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO = 16'h0000;
  localparam logic [HALF_FLOAT_W-1:0] HALF_NAN  = 16'h7E00;
  localparam logic [HALF_FLOAT_W-1:0] HALF_INF  = 16'h7C00;
  localparam logic [HALF_FLOAT_W-1:0] HALF_INFN = 16'hFC00;

  typedef enum logic [2:0] {
    ROUND_NEAREST_EVEN = 3'd0,
    ROUND_ZERO         = 3'd1,
    ROUND_UP           = 3'd2,
    ROUND_DOWN         = 3'd3,
    ROUND_NEAREST_MAX  = 3'd4
  } fpu_rounding_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  // NaN: exponent field matches the infinity pattern, fraction nonzero.
  function automatic logic is_half_nan(input logic [HALF_FLOAT_W-1:0] x);
    logic exp_ones;
    logic frac_nz;
    exp_ones = (x[14:10] == HALF_NAN[14:10]);
    frac_nz  = (x[9:0] != HALF_ZERO[9:0]);
    return exp_ones & frac_nz;
  endfunction

  function automatic logic is_half_inf(input logic [HALF_FLOAT_W-1:0] x);
    return (x == HALF_INF) || (x == HALF_INFN);
  endfunction

endpackage

// File: rtl/float_add_accumulator.sv
// Streaming binary16 reduction: feeds running sum + operand to an external
// combinational adder each accepted beat and presents the total on the last beat.
module float_add_accumulator
  import fpu_types_pkg::*;
#(
  parameter int                     FLOAT_WIDTH = HALF_FLOAT_W,
  parameter int                     COUNT_W     = 8,
  parameter logic [FLOAT_WIDTH-1:0] ACC_INIT    = HALF_ZERO
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] in_data,
  input  logic                   in_last,
  input  fpu_rounding_mode_t     rounding_mode,
  output logic [FLOAT_WIDTH-1:0] add_float1,
  output logic [FLOAT_WIDTH-1:0] add_float2,
  output fpu_rounding_mode_t     add_rounding_mode,
  input  logic [FLOAT_WIDTH-1:0] add_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT_WIDTH-1:0] out_data,
  output logic [COUNT_W-1:0]     out_count,
  output logic                   out_count_sat,
  output logic                   out_nan,
  output logic                   out_inf
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  fsm_state_t             state_reg;
  fpu_rounding_mode_t     mode_reg;
  logic [FLOAT_WIDTH-1:0] acc_reg;
  logic [COUNT_W-1:0]     count_reg;
  logic                   count_sat_reg;
  logic                   nan_reg;
  logic                   inf_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;

  logic accept;
  logic at_max;

  assign accept = in_valid & in_ready_reg;
  assign at_max = (count_reg == COUNT_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      mode_reg      <= ROUND_NEAREST_EVEN;
      acc_reg       <= ACC_INIT;
      count_reg     <= '0;
      count_sat_reg <= 1'b0;
      nan_reg       <= 1'b0;
      inf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      // Beat bookkeeping is shared by IDLE and ACCUM; DONE never accepts.
      if (accept) begin
        acc_reg <= add_sum;
        if (at_max) count_sat_reg <= 1'b1;
        else        count_reg     <= count_reg + COUNT_ONE;
        nan_reg <= nan_reg | is_half_nan(add_sum);
        inf_reg <= inf_reg | is_half_inf(add_sum);
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            mode_reg <= rounding_mode;
            if (in_last) begin
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept && in_last) begin
            state_reg     <= DONE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            acc_reg       <= ACC_INIT;
            count_reg     <= '0;
            count_sat_reg <= 1'b0;
            nan_reg       <= 1'b0;
            inf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // The first beat must round with the caller's mode before it is latched.
  assign add_rounding_mode = (state_reg == IDLE) ? rounding_mode : mode_reg;
  assign add_float1        = acc_reg;
  assign add_float2        = in_data;

  assign in_ready      = in_ready_reg;
  assign out_valid     = out_valid_reg;
  assign out_data      = acc_reg;
  assign out_count     = count_reg;
  assign out_count_sat = count_sat_reg;
  assign out_nan       = nan_reg;
  assign out_inf       = inf_reg;

endmodule

// File: tb/tb_float_add_accumulator.sv
// Directed scoreboard bench for float_add_accumulator; a behavioural binary16
// adder stands in for float_add on the add_* ports.
module tb_float_add_accumulator;
  import fpu_types_pkg::*;

  logic               CLK;
  logic               RST;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        in_data;
  logic               in_last;
  fpu_rounding_mode_t rounding_mode;
  logic [15:0]        add_float1;
  logic [15:0]        add_float2;
  fpu_rounding_mode_t add_rounding_mode;
  logic [15:0]        add_sum;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        out_data;
  logic [7:0]         out_count;
  logic               out_count_sat;
  logic               out_nan;
  logic               out_inf;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  count;
    logic        sat;
    logic        nan;
    logic        inf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  float_add_accumulator #(.FLOAT_WIDTH(16), .COUNT_W(8), .ACC_INIT(16'h0000)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .rounding_mode(rounding_mode),
    .add_float1(add_float1), .add_float2(add_float2),
    .add_rounding_mode(add_rounding_mode), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_count_sat(out_count_sat),
    .out_nan(out_nan), .out_inf(out_inf)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      m = real'(int'(h[9:0])) / 16777216.0;
    end else begin
      m = real'(int'({1'b1, h[9:0]}));
      for (int i = 0; i < e; i++) m = m * 2.0;
      m = m / 33554432.0;
    end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   ex;
    int   man;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a >= 65520.0) return {s, 15'h7C00};
    if (a < 0.00006103515625) begin
      man = $rtoi(a * 16777216.0 + 0.5);
      return {s, 15'(man)};
    end
    ex = 0;
    while (a >= 2.0) begin a = a / 2.0; ex++; end
    while (a < 1.0)  begin a = a * 2.0; ex--; end
    man = $rtoi(a * 1024.0 + 0.5);
    if (man == 2048) begin man = 1024; ex++; end
    if (ex > 15) return {s, 15'h7C00};
    return {s, 5'(ex + 15), 10'(man - 1024)};
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf = (a[14:0] == 15'h7C00);
    b_inf = (b[14:0] == 15'h7C00);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    return r2h(h2r(a) + h2r(b));
  endfunction

  always_comb add_sum = model_add(add_float1, add_float2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input logic [15:0] d, input logic [7:0] c,
                               input logic s, input logic n, input logic i);
    exp_t e;
    e.data = d; e.count = c; e.sat = s; e.nan = n; e.inf = i;
    sb.push_back(e);
  endtask

  // Called #1 after the edge that accepted the last beat.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"},  out_data,      e.data);
      chk({tag, "_count"}, out_count,     e.count);
      chk({tag, "_sat"},   out_count_sat, e.sat);
      chk({tag, "_nan"},   out_nan,       e.nan);
      chk({tag, "_inf"},   out_inf,       e.inf);
      $display("txn %s data=%h count=%0d sat=%0b nan=%0b inf=%0b",
               tag, out_data, out_count, out_count_sat, out_nan, out_inf);
      in_valid = 1'b1;
      in_data  = 16'h4000;
      for (int k = 0; k < hold; k++) begin
        @(posedge CLK);
        #1;
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_ready"}, in_ready,  0);
        chk({tag, "_hold_data"},  out_data,  e.data);
        chk({tag, "_hold_count"}, out_count, e.count);
      end
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, "_post_valid"}, out_valid,  0);
      chk({tag, "_post_ready"}, in_ready,   1);
      chk({tag, "_post_acc"},   add_float1, 16'h0000);
      chk({tag, "_post_count"}, out_count,  0);
      chk({tag, "_post_flags"}, {out_count_sat, out_nan, out_inf}, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,      1);
    chk({tag, "_out_valid"}, out_valid,     0);
    chk({tag, "_out_data"},  out_data,      16'h0000);
    chk({tag, "_out_count"}, out_count,     0);
    chk({tag, "_flags"},     {out_count_sat, out_nan, out_inf}, 0);
    chk({tag, "_float1"},    add_float1,    16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    in_last = 1'b0;
    out_ready = 1'b0;
    rounding_mode = ROUND_NEAREST_EVEN;
    #2;
    check_reset_outputs("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // 1 + 2 + 0.5 = 3.5
    expect_result(16'h4300, 8'd3, 1'b0, 1'b0, 1'b0);
    send(16'h3C00, 1'b0);
    in_data = 16'h4000;
    chk("sum3_float1", add_float1, 16'h3C00);
    chk("sum3_float2", add_float2, 16'h4000);
    send(16'h4000, 1'b0);
    send(16'h3800, 1'b1);
    collect("sum3", 0);

    // max + max overflows to +inf
    expect_result(16'h7C00, 8'd2, 1'b0, 1'b0, 1'b1);
    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    collect("ovf", 0);

    // NaN propagates; mode latched on first beat, later changes ignored
    rounding_mode = ROUND_DOWN;
    #1;
    chk("mode_idle_pass", add_rounding_mode, ROUND_DOWN);
    expect_result(16'h7E00, 8'd3, 1'b0, 1'b1, 1'b0);
    send(16'h3C00, 1'b0);
    rounding_mode = ROUND_UP;
    #1;
    chk("mode_latched", add_rounding_mode, ROUND_DOWN);
    send(16'h7E00, 1'b0);
    send(16'h3C00, 1'b1);
    collect("nan", 0);
    chk("mode_idle_after", add_rounding_mode, ROUND_UP);
    rounding_mode = ROUND_NEAREST_EVEN;

    // cancellation with output backpressure for 5 cycles
    expect_result(16'h0000, 8'd2, 1'b0, 1'b0, 1'b0);
    send(16'h3C00, 1'b0);
    send(16'hBC00, 1'b1);
    collect("cancel_hold", 5);

    // 300 beats saturate the 8-bit counter
    expect_result(16'h0000, 8'd255, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 299; b++) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    collect("saturate", 0);

    // asynchronous reset mid-stream discards the partial sum
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    chk("partial_acc", add_float1, 16'h4000);
    RST = 1'b1;
    #1;
    check_reset_outputs("midreset");
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    expect_result(16'h4000, 8'd1, 1'b0, 1'b0, 1'b0);
    send(16'h4000, 1'b1);
    collect("fresh", 0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
